// File: rtl/mshr_entry_pool_pkg.sv
// Shared types for the MSHR free-entry pool: entry index, free count and pool FSM state.
// Pure declarations; no timing or flow control of its own.
package mshr_pkg;
  localparam int ENTRY_NUM_DEF      = 32;
  localparam int ENTRY_ID_WIDTH_DEF = $clog2(ENTRY_NUM_DEF);

  typedef logic [ENTRY_ID_WIDTH_DEF-1:0] entry_id_t;
  typedef logic [ENTRY_ID_WIDTH_DEF:0]   free_cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } pool_state_e;
endpackage

// File: rtl/cmn_bin2oh.sv
// Binary index to one-hot vector, gated by a valid; purely combinational, no flow control.
module cmn_bin2oh #(
  parameter int N = 32,
  parameter int W = $clog2(N)
) (
  input  logic         i_vld,
  input  logic [W-1:0] i_idx,
  output logic [N-1:0] o_oh
);
  always_comb begin
    o_oh = '0;
    if (i_vld) o_oh[i_idx] = 1'b1;
  end
endmodule

// File: rtl/mshr_entry_pool.sv
// MSHR free-entry pool: offers free entries to the pre-allocator, takes them back on two release ports.
// All outputs registered (1-cycle update latency); no backpressure, illegal grabs/releases only flag errors.
module mshr_entry_pool
  import mshr_pkg::*;
#(
  parameter int ENTRY_NUM      = ENTRY_NUM_DEF,
  parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
  parameter int LOW_THRESH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ENTRY_NUM-1:0]      v_free_vld,
  input  logic [ENTRY_NUM-1:0]      v_alloc_oh,
  input  logic                      rel_vld_0,
  input  logic [ENTRY_ID_WIDTH-1:0] rel_idx_0,
  input  logic                      rel_vld_1,
  input  logic [ENTRY_ID_WIDTH-1:0] rel_idx_1,
  input  logic                      flush_req,
  output logic                      flush_ack,
  output logic [ENTRY_ID_WIDTH:0]   free_cnt,
  output logic                      pool_low,
  input  logic                      err_clr,
  output logic                      err_dbl_rel,
  output logic                      err_bad_alloc
);
  localparam int CW = ENTRY_ID_WIDTH + 1;
  localparam logic [CW-1:0] LP_LOW  = CW'(LOW_THRESH);
  localparam logic [CW-1:0] LP_FULL = CW'(ENTRY_NUM);

  pool_state_e          r_state;
  logic [ENTRY_NUM-1:0] r_free;
  logic [CW-1:0]        r_free_cnt;
  logic                 r_pool_low;
  logic                 r_flush_ack;
  logic                 r_err_dbl;
  logic                 r_err_bad;

  logic [ENTRY_NUM-1:0] w_offer;
  logic [ENTRY_NUM-1:0] w_rel_oh_0;
  logic [ENTRY_NUM-1:0] w_rel_oh_1;
  logic [ENTRY_NUM-1:0] w_legal_alloc;
  logic [ENTRY_NUM-1:0] w_free_d;
  logic [CW-1:0]        w_cnt_d;
  logic                 w_bad_alloc;
  logic                 w_dbl_rel;

  cmn_bin2oh #(.N(ENTRY_NUM), .W(ENTRY_ID_WIDTH)) u_rel_oh_0 (
    .i_vld (rel_vld_0),
    .i_idx (rel_idx_0),
    .o_oh  (w_rel_oh_0)
  );

  cmn_bin2oh #(.N(ENTRY_NUM), .W(ENTRY_ID_WIDTH)) u_rel_oh_1 (
    .i_vld (rel_vld_1),
    .i_idx (rel_idx_1),
    .o_oh  (w_rel_oh_1)
  );

  // Offer comes from flops only so the pre-allocator sees no input-to-output path.
  assign w_offer       = (r_state == IDLE) ? r_free : '0;
  assign w_legal_alloc = v_alloc_oh & w_offer;
  assign w_bad_alloc   = |(v_alloc_oh & ~w_offer);
  assign w_dbl_rel     = (|(w_rel_oh_0 & r_free)) | (|(w_rel_oh_1 & r_free)) |
                         (rel_vld_0 && rel_vld_1 && (rel_idx_0 == rel_idx_1));
  assign w_free_d      = (r_free & ~w_legal_alloc) | w_rel_oh_0 | w_rel_oh_1;

  always_comb begin
    w_cnt_d = '0;
    for (int i = 0; i < ENTRY_NUM; i++) w_cnt_d = w_cnt_d + CW'(w_free_d[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_free     <= '1;
      r_free_cnt <= LP_FULL;
      r_pool_low <= (ENTRY_NUM <= LOW_THRESH);
      r_err_dbl  <= 1'b0;
      r_err_bad  <= 1'b0;
    end else begin
      r_free     <= w_free_d;
      r_free_cnt <= w_cnt_d;
      r_pool_low <= (w_cnt_d <= LP_LOW);
      r_err_dbl  <= w_dbl_rel | (r_err_dbl & ~err_clr);
      r_err_bad  <= w_bad_alloc | (r_err_bad & ~err_clr);
    end
  end

  // Abort takes priority over completion when flush_req drops in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_flush_ack <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (flush_req) r_state <= DRAIN;
        DRAIN: begin
          if (!flush_req) begin
            r_state <= IDLE;
          end else if (&w_free_d) begin
            r_state     <= DONE;
            r_flush_ack <= 1'b1;
          end
        end
        DONE: begin
          if (!flush_req) begin
            r_state     <= IDLE;
            r_flush_ack <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_flush_ack <= 1'b0;
        end
      endcase
    end
  end

  assign v_free_vld    = w_offer;
  assign free_cnt      = r_free_cnt;
  assign pool_low      = r_pool_low;
  assign flush_ack     = r_flush_ack;
  assign err_dbl_rel   = r_err_dbl;
  assign err_bad_alloc = r_err_bad;
endmodule
